// File: rtl/alu64bit_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational alu64bit between two
// requesters: accept one op, drive registered operands for one EXEC cycle, return the result.
module alu64bit_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    input  logic             req1_cin,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_cout,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready is a function of state and valid, and valid never waits on ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             grant_id;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cin_d      = cin_q;
        s_d        = s_q;
        cout_d     = cout_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        // A lone requester wins outright; on a tie the round-robin pointer decides.
        grant_id   = (req0_valid && req1_valid) ? prio_q : req1_valid;

        case (state_q)
            IDLE: begin
                req0_ready = req0_valid && !grant_id;
                req1_ready = req1_valid && grant_id;
                if (req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    op_d    = req0_op;
                    cin_d   = req0_cin;
                    owner_d = 1'b0;
                    state_d = EXEC;
                end else if (req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    op_d    = req1_op;
                    cin_d   = req1_cin;
                    owner_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                s_d     = alu_s;
                cout_d  = alu_cout;
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    prio_d  = !owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            cin_q   <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign alu_cin  = cin_q;
    assign rsp_s    = s_q;
    assign rsp_cout = cout_q;
    assign busy     = (state_q != IDLE);

endmodule
